instr_issue: RTL

- Instruction fetch/issue sequencer: the initiator that drives the opcode decoder's `enable`/`opCode` inputs.
- Fetches 16-bit instruction words from program memory at `pc`, classifies the 4-bit opcode and issues it to the decoder.
- Holds `enable` until the executing unit (move/movi datapath) returns `exec_done`, then advances `pc`.
- Sits between program memory and the decoder/execute units.

---
 rtl/instr_issue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instr_issue.sv
// instr_issue: fetch/issue sequencer driving the opcode decoder enable/opCode.
// Optional WAIT_DONE watchdog is compiled in with ISSUE_TIMEOUT_EN.
module instr_issue #(
    parameter int ADDR_W         = 8,
    parameter int INSTR_W        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_valid,
    output logic               enable,
    output logic [3:0]         opCode,
    output logic [INSTR_W-5:0] operand,
    input  logic               exec_done,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               illegal,
    output logic               fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_MEM, S_ISSUE, S_WAIT_DONE, S_HALT
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q, addr_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [3:0]          op_q;
    logic [INSTR_W-5:0]  opr_q;
    logic                rd_q, en_q, halt_q, ill_q;
    logic [ADDR_W-1:0]   pc_inc;
    logic [3:0]          ir_op;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign ir_op  = ir_q[INSTR_W-1 -: 4];

`ifdef ISSUE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            op_q    <= '0;
            opr_q   <= '0;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            halt_q  <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            ill_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        rd_q    <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_q    <= 1'b0;
                    state_q <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    if (mem_valid) begin
                        ir_q    <= mem_rdata;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    case (ir_op)
                        4'b0111, 4'b1111: begin
                            op_q    <= ir_op;
                            opr_q   <= ir_q[INSTR_W-5:0];
                            en_q    <= 1'b1;
                            state_q <= S_WAIT_DONE;
`ifdef ISSUE_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                        4'b0000: begin
                            halt_q  <= 1'b1;
                            state_q <= S_HALT;
                        end
                        default: begin
                            ill_q   <= 1'b1;
                            pc_q    <= pc_inc;
                            rd_q    <= run;
                            addr_q  <= pc_inc;
                            state_q <= run ? S_FETCH : S_IDLE;
                        end
                    endcase
                end
                S_WAIT_DONE: begin
                    if (exec_done) begin
                        en_q    <= 1'b0;
                        pc_q    <= pc_inc;
                        rd_q    <= run;
                        addr_q  <= pc_inc;
                        state_q <= run ? S_FETCH : S_IDLE;
                    end
`ifdef ISSUE_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        en_q    <= 1'b0;
                        fault_q <= 1'b1;
                        halt_q  <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_HALT: begin
                    // pc still points at the HALT word so a restart re-fetches it
                    if (!run) begin
                        halt_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr = addr_q;
    assign mem_rd   = rd_q;
    assign enable   = en_q;
    assign opCode   = op_q;
    assign operand  = opr_q;
    assign pc       = pc_q;
    assign halted   = halt_q;
    assign illegal  = ill_q;

endmodule
